br_hazard_ctrl: RTL and testbench

Sequencing controller for the ID-stage branch resolver of the pipelined CPU. It detects when a branch/jump-register in ID needs an rs/rt value that the pipeline has not produced yet. It stalls PC and IF/ID and injects bubbles into ID/EX for the required number of cycles. It selects the comparator operand forwarding sources, gates the branch redirect, and keeps saturating performance counters.

---
 rtl/br_hazard_ctrl_if.sv | 46 ++++
 rtl/br_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_br_hazard_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/br_hazard_ctrl_if.sv
// Pipeline <-> ID-stage branch hazard controller signal bundle.
// The pipeline side drives the stage state; the controller returns stall/forward/redirect.
interface br_hazard_ctrl_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned CNT_W = 32;

  logic             id_valid;
  logic             id_is_br;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             ex_wen;
  logic             ex_load;
  logic [REG_W-1:0] ex_rd;
  logic             mem_wen;
  logic             mem_load;
  logic [REG_W-1:0] mem_rd;
  logic             wb_wen;
  logic [REG_W-1:0] wb_rd;
  logic             br_flag;
  logic             flush;

  logic             stall;
  logic             idex_bubble;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
  logic             pc_redirect;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output id_valid, id_is_br, id_use_rs, id_use_rt, id_rs, id_rt,
           ex_wen, ex_load, ex_rd, mem_wen, mem_load, mem_rd,
           wb_wen, wb_rd, br_flag, flush,
    input  stall, idex_bubble, fwd_a, fwd_b, pc_redirect, stall_cnt, taken_cnt
  );

  modport slave (
    input  id_valid, id_is_br, id_use_rs, id_use_rt, id_rs, id_rt,
           ex_wen, ex_load, ex_rd, mem_wen, mem_load, mem_rd,
           wb_wen, wb_rd, br_flag, flush,
    output stall, idex_bubble, fwd_a, fwd_b, pc_redirect, stall_cnt, taken_cnt
  );
endinterface

// File: rtl/br_hazard_ctrl.sv
// ID-stage branch hazard controller: stalls branches/jr whose operands are not
// yet available, picks comparator forwarding sources, gates the redirect and
// keeps saturating stall/taken counters.
module br_hazard_ctrl (
  input  logic            clk,
  input  logic            rst,
  br_hazard_ctrl_if.slave bus
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned HZ_W  = 2;
  localparam int unsigned CNT_W = 32;

  localparam logic [FWD_W-1:0] FWD_RF  = FWD_W'(0);
  localparam logic [FWD_W-1:0] FWD_MEM = FWD_W'(1);
  localparam logic [FWD_W-1:0] FWD_WB  = FWD_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q;
  logic [HZ_W-1:0]   cnt_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  taken_cnt_q;

  logic              rs_live;
  logic              rt_live;
  logic [HZ_W-1:0]   need_rs;
  logic [HZ_W-1:0]   need_rt;
  logic [HZ_W-1:0]   hazard;
  logic              stall_c;
  logic              redirect_c;

  // Cycles a live source must wait for its producer in EX or MEM.
  function automatic logic [HZ_W-1:0] need_cycles(
    input logic             live,
    input logic [REG_W-1:0] r,
    input logic             ex_wen, ex_load,
    input logic [REG_W-1:0] ex_rd,
    input logic             mem_wen, mem_load,
    input logic [REG_W-1:0] mem_rd
  );
    logic [HZ_W-1:0] n;
    n = HZ_W'(0);
    if (live) begin
      if (ex_wen && ex_rd == r)            n = ex_load ? HZ_W'(2) : HZ_W'(1);
      else if (mem_wen && mem_load && mem_rd == r) n = HZ_W'(1);
    end
    return n;
  endfunction

  // Comparator operand source; register 0 always reads the register file.
  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic [REG_W-1:0] r,
    input logic             mem_wen, mem_load,
    input logic [REG_W-1:0] mem_rd,
    input logic             wb_wen,
    input logic [REG_W-1:0] wb_rd
  );
    logic [FWD_W-1:0] f;
    f = FWD_RF;
    if (r != '0) begin
      if (mem_wen && !mem_load && mem_rd == r) f = FWD_MEM;
      else if (wb_wen && wb_rd == r)           f = FWD_WB;
    end
    return f;
  endfunction

  // Hazard depth as the worse of the two sources.
  always_comb begin
    rs_live = bus.id_valid && bus.id_is_br && bus.id_use_rs && (bus.id_rs != '0);
    rt_live = bus.id_valid && bus.id_is_br && bus.id_use_rt && (bus.id_rt != '0);
    need_rs = need_cycles(rs_live, bus.id_rs, bus.ex_wen, bus.ex_load, bus.ex_rd,
                          bus.mem_wen, bus.mem_load, bus.mem_rd);
    need_rt = need_cycles(rt_live, bus.id_rt, bus.ex_wen, bus.ex_load, bus.ex_rd,
                          bus.mem_wen, bus.mem_load, bus.mem_rd);
    hazard  = (need_rs > need_rt) ? need_rs : need_rt;
  end

  // Same-cycle stall, bubble, forwarding and redirect; flush overrides all.
  always_comb begin
    stall_c    = 1'b0;
    redirect_c = 1'b0;
    if (!bus.flush) begin
      stall_c    = (state_q == HOLD) || (hazard != '0);
      redirect_c = bus.br_flag && bus.id_valid && bus.id_is_br &&
                   (state_q == RUN) && (hazard == '0);
    end
    bus.stall       = stall_c;
    bus.idex_bubble = stall_c;
    bus.pc_redirect = redirect_c;
    bus.fwd_a       = fwd_sel(bus.id_rs, bus.mem_wen, bus.mem_load, bus.mem_rd,
                              bus.wb_wen, bus.wb_rd);
    bus.fwd_b       = fwd_sel(bus.id_rt, bus.mem_wen, bus.mem_load, bus.mem_rd,
                              bus.wb_wen, bus.wb_rd);
    bus.stall_cnt   = stall_cnt_q;
    bus.taken_cnt   = taken_cnt_q;
  end

  // RUN/HOLD sequencing: a load in EX holds one extra cycle via cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard == HZ_W'(2)) begin
            cnt_q   <= HZ_W'(1);
            state_q <= HOLD;
          end
        end
        HOLD: begin
          cnt_q <= (cnt_q == '0) ? '0 : cnt_q - HZ_W'(1);
          if (cnt_q <= HZ_W'(1)) state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (stall_c && stall_cnt_q != CNT_MAX)    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect_c && taken_cnt_q != CNT_MAX) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_br_hazard_ctrl.sv
// Scoreboard bench for br_hazard_ctrl: each stimulus cycle pushes its expected
// outputs, which are popped and compared mid-cycle; counters follow a small model.
module tb_br_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  br_hazard_ctrl_if bus ();

  br_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       redir;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_sc;
  logic [31:0] exp_tc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
  endtask

  task automatic clr_in();
    bus.id_valid  = 0; bus.id_is_br = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_rs     = 0; bus.id_rt    = 0;
    bus.ex_wen    = 0; bus.ex_load  = 0; bus.ex_rd     = 0;
    bus.mem_wen   = 0; bus.mem_load = 0; bus.mem_rd    = 0;
    bus.wb_wen    = 0; bus.wb_rd    = 0;
    bus.br_flag   = 0; bus.flush    = 0;
  endtask

  task automatic branch(input logic urs, input logic urt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic br);
    bus.id_valid = 1; bus.id_is_br = 1; bus.id_use_rs = urs; bus.id_use_rt = urt;
    bus.id_rs = rs; bus.id_rt = rt; bus.br_flag = br;
  endtask

  task automatic set_ex(input logic wen, input logic ld, input logic [4:0] rd);
    bus.ex_wen = wen; bus.ex_load = ld; bus.ex_rd = rd;
  endtask

  task automatic set_mem(input logic wen, input logic ld, input logic [4:0] rd);
    bus.mem_wen = wen; bus.mem_load = ld; bus.mem_rd = rd;
  endtask

  task automatic set_wb(input logic wen, input logic [4:0] rd);
    bus.wb_wen = wen; bus.wb_rd = rd;
  endtask

  // One cycle: push expectation, compare mid-cycle, advance past the edge.
  task automatic step(input string tag, input logic st, input logic [1:0] fa,
                      input logic [1:0] fb, input logic rd);
    exp_t e;
    e.stall = st; e.fa = fa; e.fb = fb; e.redir = rd;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".stall"},  32'(bus.stall),       32'(e.stall));
    check({tag, ".bubble"}, 32'(bus.idex_bubble), 32'(e.stall));
    check({tag, ".fwd_a"},  32'(bus.fwd_a),       32'(e.fa));
    check({tag, ".fwd_b"},  32'(bus.fwd_b),       32'(e.fb));
    check({tag, ".redir"},  32'(bus.pc_redirect), 32'(e.redir));
    @(posedge clk);
    #1;
    if (e.stall && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
    if (e.redir && exp_tc != 32'hFFFF_FFFF) exp_tc = exp_tc + 32'd1;
  endtask

  task automatic chk_cnt(input string tag);
    check({tag, ".stall_cnt"}, bus.stall_cnt, exp_sc);
    check({tag, ".taken_cnt"}, bus.taken_cnt, exp_tc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    clr_in();
    exp_sc = 0;
    exp_tc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.stall", 32'(bus.stall), 32'd0);
    check("rst.redir", 32'(bus.pc_redirect), 32'd0);
    chk_cnt("rst");
    rst = 0;
    step("idle", 0, 0, 0, 0);
    chk_cnt("idle");

    // lw $3 in EX, beq $3,$4: two stalls, then resolve with WB forward
    clr_in(); branch(1, 1, 3, 4, 1); set_ex(1, 1, 3);  step("lw_t0", 1, 0, 0, 0);
    clr_in(); branch(1, 1, 3, 4, 1); set_mem(1, 1, 3); step("lw_t1", 1, 0, 0, 0);
    clr_in(); branch(1, 1, 3, 4, 1); set_wb(1, 3);     step("lw_t2", 0, 2, 0, 1);
    check("lw.stall_cnt", bus.stall_cnt, 32'd2);
    check("lw.taken_cnt", bus.taken_cnt, 32'd1);

    // add $5 in EX, bne $5,$0: one stall, then MEM forward; $0 never forwards
    clr_in(); branch(1, 1, 5, 0, 0); set_ex(1, 0, 5); step("alu_t0", 1, 0, 0, 0);
    clr_in(); branch(1, 1, 5, 0, 0); set_mem(1, 0, 5); set_wb(1, 0);
    step("alu_t1", 0, 1, 0, 0);

    // jr $0 against a load writing $0: no hazard, redirect follows br_flag
    clr_in(); branch(1, 0, 0, 0, 1); set_ex(1, 1, 0); step("jr0_tk", 0, 0, 0, 1);
    clr_in(); branch(1, 0, 0, 0, 0); set_ex(1, 1, 0); step("jr0_nt", 0, 0, 0, 0);

    // Liveness gating
    clr_in(); branch(1, 0, 6, 0, 1); bus.id_valid = 0; set_ex(1, 1, 6);
    step("inval", 0, 0, 0, 0);
    clr_in(); branch(1, 0, 6, 0, 1); bus.id_is_br = 0; set_ex(1, 1, 6);
    step("notbr", 0, 0, 0, 0);
    clr_in(); branch(0, 1, 6, 9, 1); set_ex(1, 1, 6); step("nouse", 0, 0, 0, 1);

    // rs needs 1 (MEM load), rt needs 2 (EX load): the larger governs
    clr_in(); branch(1, 1, 7, 8, 1); set_mem(1, 1, 7); set_ex(1, 1, 8);
    step("max_t0", 1, 0, 0, 0);
    clr_in(); branch(1, 1, 7, 8, 1); step("max_t1", 1, 0, 0, 0);
    clr_in(); branch(1, 1, 7, 8, 1); step("max_t2", 0, 0, 0, 1);

    // MEM-load hazard alone: one stall in RUN, then re-evaluated
    clr_in(); branch(1, 0, 9, 0, 1); set_mem(1, 1, 9); step("mld_t0", 1, 0, 0, 0);
    clr_in(); branch(1, 0, 9, 0, 1); set_wb(1, 9);     step("mld_t1", 0, 2, 0, 1);

    // Forward priority and forwarding during a stalled cycle
    clr_in(); branch(1, 1, 10, 11, 0); set_mem(1, 0, 10); set_wb(1, 11);
    step("fwd_mix", 0, 1, 2, 0);
    clr_in(); branch(1, 1, 12, 12, 0); set_mem(1, 0, 12); set_wb(1, 12);
    step("fwd_pri", 0, 1, 1, 0);
    clr_in(); branch(1, 0, 13, 0, 0); set_mem(1, 1, 13); set_wb(1, 13);
    step("fwd_stl", 1, 2, 0, 0);
    chk_cnt("mid");

    // Flush in the HOLD cycle: no stall that cycle, RUN afterwards
    clr_in(); branch(1, 1, 3, 0, 1); set_ex(1, 1, 3); step("fl_t0", 1, 0, 0, 0);
    clr_in(); branch(1, 1, 3, 0, 1); set_mem(1, 1, 3); bus.flush = 1;
    step("fl_t1", 0, 0, 0, 0);
    clr_in(); branch(1, 1, 3, 0, 1); step("fl_t2", 0, 0, 0, 1);
    chk_cnt("flush_hold");

    // Flush with an EX-load hazard in RUN: flush wins and HOLD is not entered
    clr_in(); branch(1, 0, 4, 0, 1); set_ex(1, 1, 4); bus.flush = 1;
    step("flrun_t0", 0, 0, 0, 0);
    clr_in(); branch(1, 0, 4, 0, 1); step("flrun_t1", 0, 0, 0, 1);
    chk_cnt("flush_run");

    // Asynchronous reset while in HOLD
    clr_in(); branch(1, 0, 3, 0, 1); set_ex(1, 1, 3); step("rh_t0", 1, 0, 0, 0);
    clr_in(); branch(1, 0, 3, 0, 1);
    #2;
    check("rh.hold_stall", 32'(bus.stall), 32'd1);
    rst = 1;
    #1;
    exp_sc = 0;
    exp_tc = 0;
    check("rh.stall", 32'(bus.stall), 32'd0);
    check("rh.bubble", 32'(bus.idex_bubble), 32'd0);
    chk_cnt("rh");
    @(posedge clk);
    #1;
    rst = 0;
    clr_in();
    step("rh_idle", 0, 0, 0, 0);
    chk_cnt("rh_idle");

    // Saturation of stall_cnt
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_sc = 32'hFFFF_FFFE;
    check("sat.pre", bus.stall_cnt, 32'hFFFF_FFFE);
    clr_in(); branch(1, 0, 3, 0, 0); set_ex(1, 1, 3);  step("sat_t0", 1, 0, 0, 0);
    check("sat.t0", bus.stall_cnt, 32'hFFFF_FFFF);
    clr_in(); branch(1, 0, 3, 0, 0); set_mem(1, 1, 3); step("sat_t1", 1, 0, 0, 0);
    check("sat.t1", bus.stall_cnt, 32'hFFFF_FFFF);
    clr_in(); branch(1, 0, 3, 0, 0); set_wb(1, 3);     step("sat_t2", 0, 2, 0, 0);
    chk_cnt("sat");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
